mul_sequencer: RTL

MUL_SEQUENCER -- requirements
Module: mul_sequencer

---
 rtl/mul_pkg.sv | 19 +
 rtl/mul_sequencer_if.sv | 34 +++
 rtl/mul_result_cache.sv | 48 ++++
 rtl/mul_sequencer.sv | 108 ++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: op_mode encodings and sequencer FSM states.
// Shared by mul_sequencer, mul_result_cache and the bench.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_LO = 2'b00,
    SMULH  = 2'b01,
    UMULH  = 2'b10,
    RSVD   = 2'b11
  } op_mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LAUNCH = 2'b01,
    WAIT   = 2'b10,
    DONE   = 2'b11
  } state_e;

endpackage

// File: rtl/mul_sequencer_if.sv
// mul_sequencer_if: core-side op/result signals and multiplier-side signals.
// slave = sequencer view, master = core + multiplier view.
interface mul_sequencer_if #(
  parameter int WIDTH = 64
);
  logic             op_valid;
  logic [1:0]       op_mode;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       mult_mode;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             start;
  logic [WIDTH-1:0] mult_result;
  logic             mult_done;
  logic             stall;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             op_err;

  modport slave (
    input  op_valid, op_mode, op_a, op_b,
    input  mult_result, mult_done,
    output mult_mode, multiplicand, multiplier, start,
    output stall, result, result_valid, op_err
  );

  modport master (
    output op_valid, op_mode, op_a, op_b,
    output mult_result, mult_done,
    input  mult_mode, multiplicand, multiplier, start,
    input  stall, result, result_valid, op_err
  );
endinterface

// File: rtl/mul_result_cache.sv
// mul_result_cache: one-entry {mode,a,b,result} store plus lookup compare.
// Ports: clk, reset (async low), wr_* capture, rd_* lookup, hit/hit_result.
module mul_result_cache
  import mul_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [1:0]       wr_mode,
  input  logic [WIDTH-1:0] wr_a,
  input  logic [WIDTH-1:0] wr_b,
  input  logic [WIDTH-1:0] wr_result,
  input  logic [1:0]       rd_mode,
  input  logic [WIDTH-1:0] rd_a,
  input  logic [WIDTH-1:0] rd_b,
  output logic             hit,
  output logic [WIDTH-1:0] hit_result
);

  logic             vld;
  op_mode_e         mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] res;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld  <= 1'b0;
      mode <= MUL_LO;
      a    <= '0;
      b    <= '0;
      res  <= '0;
    end else if (wr_en) begin
      vld  <= 1'b1;
      mode <= op_mode_e'(wr_mode);
      a    <= wr_a;
      b    <= wr_b;
      res  <= wr_result;
    end
  end

  assign hit = vld && (rd_mode == mode)
            && (rd_a == a) && (rd_b == b);
  assign hit_result = res;

endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer: launches one multiply per op and returns its result to the core.
// Ports: clk, reset (async low), bus (slave). MUL_RESULT_CACHE_EN adds a result cache.
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic           clk,
  input  logic           reset,
  mul_sequencer_if.slave bus
);

  state_e           state;
  logic             start_q;
  logic             rv_q;
  logic             err_q;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             hit;
  logic [WIDTH-1:0] hit_result;

`ifdef MUL_RESULT_CACHE_EN
  mul_result_cache #(.WIDTH(WIDTH)) u_cache (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (state == WAIT && bus.mult_done),
    .wr_mode    (mode_q),
    .wr_a       (a_q),
    .wr_b       (b_q),
    .wr_result  (bus.mult_result),
    .rd_mode    (bus.op_mode),
    .rd_a       (bus.op_a),
    .rd_b       (bus.op_b),
    .hit        (hit),
    .hit_result (hit_result)
  );
`else
  assign hit        = 1'b0;
  assign hit_result = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      start_q <= 1'b0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      mode_q  <= 2'b00;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      start_q <= 1'b0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.op_valid) begin
            if (bus.op_mode == RSVD) begin
              res_q <= '0;
              err_q <= 1'b1;
              rv_q  <= 1'b1;
              state <= DONE;
            end else begin
              mode_q <= bus.op_mode;
              a_q    <= bus.op_a;
              b_q    <= bus.op_b;
              if (hit) begin
                res_q <= hit_result;
                rv_q  <= 1'b1;
                state <= DONE;
              end else begin
                start_q <= 1'b1;
                state   <= LAUNCH;
              end
            end
          end
        end
        LAUNCH: state <= WAIT;
        WAIT: begin
          // done pulses seen in any other state are stale
          if (bus.mult_done) begin
            res_q <= bus.mult_result;
            rv_q  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

  assign bus.start        = start_q;
  assign bus.result_valid = rv_q;
  assign bus.op_err       = err_q;
  assign bus.mult_mode    = mode_q;
  assign bus.multiplicand = a_q;
  assign bus.multiplier   = b_q;
  assign bus.result       = res_q;

  // gated by reset so a held op_valid cannot stall the core during reset
  assign bus.stall = reset && (
      (bus.op_valid && state == IDLE)
    || state == LAUNCH || state == WAIT);

endmodule
